// File: rtl/dmem_rmw_arbiter.sv
// dmem_rmw_arbiter
// Shares the single port of the byte-addressed, little-endian data RAM between the CPU data port (0)
// and the debug/loader port (1) with round-robin arbitration. Byte and halfword stores are done as
// read-modify-write. Loads return zero-extended lanes. Accesses that would run past the end of the
// array are rejected without touching the RAM.
module dmem_rmw_arbiter #(
   parameter  int WORD_WIDTH = 32,
   parameter  int ENTRIES    = 100,
   localparam int AW         = $clog2(ENTRIES)
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Req0,
   input  logic                  We0,
   input  logic [1:0]            Size0,
   input  logic [AW-1:0]         Addr0,
   input  logic [WORD_WIDTH-1:0] WData0,
   input  logic                  Req1,
   input  logic                  We1,
   input  logic [1:0]            Size1,
   input  logic [AW-1:0]         Addr1,
   input  logic [WORD_WIDTH-1:0] WData1,
   output logic                  Done0,
   output logic                  Err0,
   output logic                  Done1,
   output logic                  Err1,
   output logic [WORD_WIDTH-1:0] RData,
   output logic                  Busy,
   output logic                  Mem_WE,
   output logic [AW-1:0]         Mem_A,
   output logic [WORD_WIDTH-1:0] Mem_WD,
   input  logic [WORD_WIDTH-1:0] Mem_RD
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic [1:0]  SIZE_BYTE_C  = 2'b00;
   localparam logic [1:0]  SIZE_HALF_C  = 2'b01;
   // One extra bit so that Addr + 4 cannot wrap before the depth compare.
   localparam logic [AW:0] WORD_BYTES_C = (AW+1)'(4);
   localparam logic [AW:0] DEPTH_C      = (AW+1)'(ENTRIES);

   state_t                  state_r;
   state_t                  state_s;
   logic                    rr_ptr_r;     // requester preferred when both ask
   logic                    gnt_r;
   logic                    we_r;
   logic [1:0]              size_r;
   logic [WORD_WIDTH-1:0]   wdata_r;
   logic                    done0_r;
   logic                    done1_r;
   logic                    err0_r;
   logic                    err1_r;
   logic [WORD_WIDTH-1:0]   rdata_r;
   logic [AW-1:0]           mem_a_r;
   logic [WORD_WIDTH-1:0]   mem_wd_r;

   logic                    any_req_s;
   logic                    gnt_s;
   logic                    sel_we_s;
   logic [1:0]              sel_size_s;
   logic [AW-1:0]           sel_addr_s;
   logic [WORD_WIDTH-1:0]   sel_wdata_s;
   logic                    range_bad_s;
   logic                    sel_partial_s;
   logic                    cur_gnt_s;
   logic                    done0_s;
   logic                    done1_s;
   logic                    err0_s;
   logic                    err1_s;
   logic [WORD_WIDTH-1:0]   rdata_s;
   logic [AW-1:0]           mem_a_s;
   logic [WORD_WIDTH-1:0]   mem_wd_s;

   // Zero-extended lane of a word read back from the RAM.
   function automatic logic [WORD_WIDTH-1:0] lane_extract(input logic [1:0] size,
                                                          input logic [WORD_WIDTH-1:0] rd);
      case (size)
         SIZE_BYTE_C: return {24'h000000, rd[7:0]};
         SIZE_HALF_C: return {16'h0000, rd[15:0]};
         default:     return rd;
      endcase
   endfunction

   // Old word with the low byte or halfword replaced by the store data.
   function automatic logic [WORD_WIDTH-1:0] lane_merge(input logic [1:0] size,
                                                        input logic [WORD_WIDTH-1:0] rd,
                                                        input logic [WORD_WIDTH-1:0] wd);
      case (size)
         SIZE_BYTE_C: return {rd[31:8], wd[7:0]};
         SIZE_HALF_C: return {rd[31:16], wd[15:0]};
         default:     return wd;
      endcase
   endfunction

   // Round-robin pick among pending requests; only meaningful while IDLE.
   always_comb begin
      any_req_s = Req0 | Req1;
      if (Req0 && Req1) begin
         gnt_s = rr_ptr_r;
      end else if (Req1) begin
         gnt_s = 1'b1;
      end else begin
         gnt_s = 1'b0;
      end
   end

   assign sel_we_s      = gnt_s ? We1    : We0;
   assign sel_size_s    = gnt_s ? Size1  : Size0;
   assign sel_addr_s    = gnt_s ? Addr1  : Addr0;
   assign sel_wdata_s   = gnt_s ? WData1 : WData0;
   assign range_bad_s   = ({1'b0, sel_addr_s} + WORD_BYTES_C) > DEPTH_C;
   assign sel_partial_s = (sel_size_s == SIZE_BYTE_C) || (sel_size_s == SIZE_HALF_C);
   assign cur_gnt_s     = (state_r == ST_IDLE) ? gnt_s : gnt_r;

   // State register.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!any_req_s) begin
               state_s = ST_IDLE;
            end else if (range_bad_s) begin
               state_s = ST_RESP;
            end else if (!sel_we_s || sel_partial_s) begin
               state_s = ST_READ;
            end else begin
               state_s = ST_WRITE;
            end
         end
         ST_READ: begin
            if (we_r) begin
               state_s = ST_WRITE;
            end else begin
               state_s = ST_RESP;
            end
         end
         ST_WRITE: state_s = ST_RESP;
         ST_RESP:  state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs and the RAM address/data.
   always_comb begin
      done0_s  = 1'b0;
      done1_s  = 1'b0;
      err0_s   = 1'b0;
      err1_s   = 1'b0;
      rdata_s  = rdata_r;
      mem_a_s  = mem_a_r;
      mem_wd_s = mem_wd_r;
      if (state_s == ST_RESP) begin
         done0_s = ~cur_gnt_s;
         done1_s = cur_gnt_s;
      end else begin
         done0_s = 1'b0;
         done1_s = 1'b0;
      end
      case (state_r)
         ST_IDLE: begin
            if (any_req_s && range_bad_s) begin
               err0_s = ~gnt_s;
               err1_s = gnt_s;
            end else if (any_req_s) begin
               mem_a_s = sel_addr_s;
               if (sel_we_s && !sel_partial_s) begin
                  mem_wd_s = sel_wdata_s;
               end else begin
                  mem_wd_s = mem_wd_r;
               end
            end else begin
               mem_a_s = mem_a_r;
            end
         end
         ST_READ: begin
            if (we_r) begin
               mem_wd_s = lane_merge(size_r, Mem_RD, wdata_r);
            end else begin
               rdata_s = lane_extract(size_r, Mem_RD);
            end
         end
         default: begin
            mem_a_s = mem_a_r;
         end
      endcase
   end

   // Output and RAM-port registers.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         done0_r  <= 1'b0;
         done1_r  <= 1'b0;
         err0_r   <= 1'b0;
         err1_r   <= 1'b0;
         rdata_r  <= {WORD_WIDTH{1'b0}};
         mem_a_r  <= {AW{1'b0}};
         mem_wd_r <= {WORD_WIDTH{1'b0}};
      end else begin
         done0_r  <= done0_s;
         done1_r  <= done1_s;
         err0_r   <= err0_s;
         err1_r   <= err1_s;
         rdata_r  <= rdata_s;
         mem_a_r  <= mem_a_s;
         mem_wd_r <= mem_wd_s;
      end
   end

   // Capture the granted request and advance the round-robin pointer.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         rr_ptr_r <= 1'b0;
         gnt_r    <= 1'b0;
         we_r     <= 1'b0;
         size_r   <= 2'b00;
         wdata_r  <= {WORD_WIDTH{1'b0}};
      end else if ((state_r == ST_IDLE) && any_req_s) begin
         rr_ptr_r <= ~gnt_s;
         gnt_r    <= gnt_s;
         we_r     <= sel_we_s;
         size_r   <= sel_size_s;
         wdata_r  <= sel_wdata_s;
      end else begin
         rr_ptr_r <= rr_ptr_r;
         gnt_r    <= gnt_r;
         we_r     <= we_r;
         size_r   <= size_r;
         wdata_r  <= wdata_r;
      end
   end

   // Write strobe and busy are decoded from state so they fall as soon as Rst asserts.
   assign Mem_WE = (state_r == ST_WRITE);
   assign Busy   = (state_r != ST_IDLE);
   assign Mem_A  = mem_a_r;
   assign Mem_WD = mem_wd_r;
   assign RData  = rdata_r;
   assign Done0  = done0_r;
   assign Done1  = done1_r;
   assign Err0   = err0_r;
   assign Err1   = err1_r;

endmodule
